// File: rtl/seed_random_1_card_dealer.sv
// seed_random_1_card_dealer
// Samples the free-running seed counter on a card request, reduces it modulo
// the deck size by repeated subtraction, then probes forward past dealt cards
// and presents a unique rank/suit pair with a one-cycle valid pulse.
// Optional feature macro: SEED_RANDOM_DECK_TRACK_EN enables the dealt-card
// bitmap, probing past dealt cards and deck counting. Without it, every deal
// is taken on the first PROBE cycle and cards may repeat.
module seed_random_1_card_dealer #(
  parameter int DECK_SIZE = 52,
  parameter int RANKS     = 13
) (
  input  logic       clk_dp_i,
  input  logic       rst_dp_i,
  input  logic [7:0] seed_i,
  input  logic       req_card_i,
  input  logic       shuffle_i,
  output logic       card_valid_o,
  output logic [3:0] rank_o,
  output logic [1:0] suit_o,
  output logic       busy_o,
  output logic [5:0] cards_left_o,
  output logic       deck_empty_o,
  output logic       empty_err_o
);

  typedef enum logic [1:0] {IDLE, REDUCE, PROBE} state_t;

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic       card_valid_q, card_valid_d;
  logic [3:0] rank_q, rank_d;
  logic [1:0] suit_q, suit_d;
  logic       busy_q;

  // Suit is the quarter of the deck the index falls in.
  function automatic logic [1:0] suit_of(input logic [5:0] i);
    if (i >= 6'(3 * RANKS)) return 2'd3;
    if (i >= 6'(2 * RANKS)) return 2'd2;
    if (i >= 6'(RANKS))     return 2'd1;
    return 2'd0;
  endfunction

  // Rank is the position within the suit, counted from 1.
  function automatic logic [3:0] rank_of(input logic [5:0] i);
    logic [5:0] r;
    r = i - 6'(int'(suit_of(i)) * RANKS) + 6'd1;
    return r[3:0];
  endfunction

`ifdef SEED_RANDOM_DECK_TRACK_EN
  logic [DECK_SIZE-1:0] used_q, used_d;
  logic [5:0]           cards_left_q, cards_left_d;
  logic                 empty_err_q, empty_err_d;
`endif

  // Next-state and datapath decisions for the deal sequence.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    card_valid_d = 1'b0;
    rank_d       = rank_q;
    suit_d       = suit_q;
`ifdef SEED_RANDOM_DECK_TRACK_EN
    used_d       = used_q;
    cards_left_d = cards_left_q;
    empty_err_d  = 1'b0;
`endif
    if (shuffle_i) begin
      // Shuffle wins in every state and abandons any deal in flight.
      state_d = IDLE;
`ifdef SEED_RANDOM_DECK_TRACK_EN
      used_d       = '0;
      cards_left_d = 6'(DECK_SIZE);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_card_i) begin
`ifdef SEED_RANDOM_DECK_TRACK_EN
            if (cards_left_q == 6'd0) begin
              empty_err_d = 1'b1;
            end else begin
              idx_d   = seed_i;
              state_d = REDUCE;
            end
`else
            idx_d   = seed_i;
            state_d = REDUCE;
`endif
          end
        end
        REDUCE: begin
          if (idx_q >= 8'(DECK_SIZE)) idx_d = idx_q - 8'(DECK_SIZE);
          else                        state_d = PROBE;
        end
        PROBE: begin
`ifdef SEED_RANDOM_DECK_TRACK_EN
          if (used_q[idx_q[5:0]]) begin
            idx_d = (idx_q == 8'(DECK_SIZE - 1)) ? 8'd0 : idx_q + 8'd1;
          end else begin
            used_d[idx_q[5:0]] = 1'b1;
            cards_left_d       = cards_left_q - 6'd1;
            rank_d             = rank_of(idx_q[5:0]);
            suit_d             = suit_of(idx_q[5:0]);
            card_valid_d       = 1'b1;
            state_d            = IDLE;
          end
`else
          rank_d       = rank_of(idx_q[5:0]);
          suit_d       = suit_of(idx_q[5:0]);
          card_valid_d = 1'b1;
          state_d      = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, index and output registers; reset forces everything at once.
  always_ff @(posedge clk_dp_i or negedge rst_dp_i) begin
    if (!rst_dp_i) begin
      state_q      <= IDLE;
      idx_q        <= 8'd0;
      card_valid_q <= 1'b0;
      rank_q       <= 4'd0;
      suit_q       <= 2'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      card_valid_q <= card_valid_d;
      rank_q       <= rank_d;
      suit_q       <= suit_d;
      busy_q       <= (state_d != IDLE);
    end
  end

`ifdef SEED_RANDOM_DECK_TRACK_EN
  // Dealt-card bitmap and deck bookkeeping.
  always_ff @(posedge clk_dp_i or negedge rst_dp_i) begin
    if (!rst_dp_i) begin
      used_q       <= '0;
      cards_left_q <= 6'(DECK_SIZE);
      empty_err_q  <= 1'b0;
    end else begin
      used_q       <= used_d;
      cards_left_q <= cards_left_d;
      empty_err_q  <= empty_err_d;
    end
  end

  assign cards_left_o = cards_left_q;
  assign deck_empty_o = (cards_left_q == 6'd0);
  assign empty_err_o  = empty_err_q;
`else
  assign cards_left_o = 6'(DECK_SIZE);
  assign deck_empty_o = 1'b0;
  assign empty_err_o  = 1'b0;
`endif

  assign card_valid_o = card_valid_q;
  assign rank_o       = rank_q;
  assign suit_o       = suit_q;
  assign busy_o       = busy_q;

endmodule
